twiddle_stream_gen: RTL
=======================

Name: twiddle_stream_gen

Overview:
Parametrised twiddle-factor generator for the radix-2 FFT datapath. It is the successor to the fixed 16-point per-stage twiddle table. On a start request for a given stage, it streams that stage's N/2 twiddles, LANES per beat, under a valid/ready handshake. Values are derived from a quarter-wave cosine table using octant symmetry, and an inverse mode emits conjugated twiddles for IFFT. It sits between the FFT stage controller and the butterfly array.

Parameters:
LOG2N, 4, log2 of FFT size N; legal range 3..10.
DW, 8, bits per real/imag component; sign-magnitude, scale 1.0 = 2^(DW-2).
LANES, 2, twiddles per output beat; power of two, 1..N/2.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
start_i  in  1  request a stage stream; accepted only while idle.
stage_i  in  4  stage index s, sampled with an accepted start.
inverse_i  in  1  1 = conjugate output (IFFT); sampled with an accepted start.
out_ready_i  in  1  downstream ready.
out_valid_o  out  1  beat valid.
out_data_o  out  2*DW*LANES  packed twiddles.
out_last_o  out  1  final beat of the stage.
busy_o  out  1  stream in progress.
err_o  out  1  one-cycle pulse when start is rejected for illegal stage_i.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; counters cleared. Reset mid-stream abandons the stream, with no last beat.
- FSM states are IDLE, FILL, RUN.
- IDLE -> FILL on start_i=1 with stage_i < LOG2N. Stage and inverse are latched, and busy_o=1 from the next cycle.
- start_i with stage_i >= LOG2N in IDLE: err_o=1 for the next cycle; the FSM stays in IDLE.
- start_i while busy is ignored; no error is raised.
- FILL lasts one cycle while the ROM primes the pipeline, then goes to RUN. First out_valid_o is asserted 2 cycles after the accepting edge.
- RUN: with out_ready_i held at 1, one beat is produced per cycle. The beat count is N/(2*LANES).
- Handshake: a beat transfers when out_valid_o && out_ready_i. While valid && !ready, out_data_o, out_last_o and out_valid_o hold stable. The full pipeline stalls through a global enable; no beat is dropped or duplicated.
- After the beat with out_last_o transfers, the FSM returns to IDLE and busy_o goes to 0 on the same edge. A new start is accepted the cycle after that.
- Twiddle index j = beat*LANES + l for lane l, where j = 0..N/2-1.
  - Exponent e = (j mod 2^s) * 2^(LOG2N-1-s).
  - Twiddle W = exp(-j*2*pi*e/N).
- Packing: lane l occupies bits [2*DW*(l+1)-1 : 2*DW*l]. Real is in the upper DW bits, imag in the lower DW bits.
- Quarter table: C[m] = round(cos(2*pi*m/N) * 2^(DW-2)) for m=0..N/4. Rounding is half away from zero, and magnitudes are DW-1 bits.
- Symmetry, forward direction:
  - For e < N/4: re = +C[e], im = -C[N/4-e].
  - For e >= N/4, with e' = e-N/4: re = -C[N/4-e'], im = -C[e'].
- Inverse mode negates imag.
- A zero magnitude always carries sign bit 0; there is no negative zero.
- LANES table reads per beat use one qrom instance per lane, addressed in parallel.

Decomposition:
- Package twiddle_pkg holds:
  - the sign-magnitude pack/negate helper functions;
  - the FSM state encoding;
  - the constant function that builds C[] at elaboration using real arithmetic.
- Sub-module twiddle_qrom, instantiated LANES times: a registered-read quarter-wave magnitude table with clock, enable, address and magnitude ports. Its contents come from the twiddle_pkg function, parametrised by LOG2N and DW.

Test Plan:
- N=16, DW=8, LANES=2, stage 0, forward:
  - Start -> 4 beats, every lane 0x4000.
  - First valid 2 cycles after start; last on beat 3; busy drops after beat 3.
- Stage 1 -> every beat is lane0 0x4000, lane1 0x00C0 (e=0,4).
- Stage 3 forward:
  - beat1 -> lane0 (e=2) 0x2DAD, lane1 (e=3) 0x18BB.
  - beat3 -> lane1 (e=7) 0xBB98.
- Stage 1 with inverse_i=1 -> lane1 0x0040; lane0 stays 0x4000 (no negative zero).
- Backpressure on stage 3: out_ready_i toggled 1,0,0,1,... -> data held stable while stalled; exactly 4 distinct beats in order; start pulses during busy are ignored.
- Illegal stage and reset:
  - stage_i=4 -> err_o pulses once, no valid, busy stays 0.
  - reset asserted on beat 2 -> next cycle all outputs 0, FSM in IDLE.
  - A following start works normally.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the twiddle stream generator:
// FSM encoding, sign-magnitude pack/negate, and the quarter-wave cosine builder.
package twiddle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int unsigned SM_MAXW = 32;
    localparam real         TWO_PI  = 6.283185307179586;

    // C[m] = round(cos(2*pi*m/N) * 2^(dw-2)); entries past N/4 read as zero.
    function automatic int unsigned quarter_cos(input int unsigned m,
                                                input int unsigned log2n,
                                                input int unsigned dw);
        real x;
        int unsigned q;
        q = 1 << (log2n - 2);
        if (m > q) return 0;
        x = $cos(TWO_PI * real'(m) / real'(1 << log2n)) * real'(1 << (dw - 2));
        return $unsigned($rtoi(x + 0.5));
    endfunction

    // Sign bit is forced low for a zero magnitude so there is no negative zero.
    function automatic logic [SM_MAXW-1:0] sm_pack(input logic              neg,
                                                   input logic [SM_MAXW-1:0] mag,
                                                   input int unsigned        dw);
        logic [SM_MAXW-1:0] v;
        v         = mag;
        v[dw - 1] = neg && (mag != '0);
        return v;
    endfunction

    function automatic logic [SM_MAXW-1:0] sm_negate(input logic [SM_MAXW-1:0] v,
                                                     input int unsigned        dw);
        logic [SM_MAXW-1:0] mag;
        mag = v & ((SM_MAXW'(1) << (dw - 1)) - SM_MAXW'(1));
        return sm_pack(!v[dw - 1], mag, dw);
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Registered-read quarter-wave cosine magnitude table with two read addresses
// (real and imaginary magnitudes of one lane are fetched in the same cycle).
module twiddle_qrom import twiddle_pkg::*; #(
    parameter int LOG2N = 4,
    parameter int DW    = 8
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic [LOG2N-2:0] i_addr_a,
    input  logic [LOG2N-2:0] i_addr_b,
    output logic [DW-2:0]    o_mag_a,
    output logic [DW-2:0]    o_mag_b
);

    localparam int DEPTH = 1 << (LOG2N - 1);

    logic [DW-2:0] w_tab [DEPTH];

    for (genvar m = 0; m < DEPTH; m++) begin : g_tab
        assign w_tab[m] = (DW-1)'(quarter_cos(m, LOG2N, DW));
    end

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            o_mag_a <= w_tab[i_addr_a];
            o_mag_b <= w_tab[i_addr_b];
        end
    end

endmodule

// File: rtl/twiddle_stream_gen.sv
// Streams the N/2 twiddles of one radix-2 FFT stage, LANES per beat, through a
// two-stage (ROM, output) pipeline stalled by a single global enable.
module twiddle_stream_gen import twiddle_pkg::*; #(
    parameter int LOG2N = 4,
    parameter int DW    = 8,
    parameter int LANES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            stage_i,
    input  logic                  inverse_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [2*DW*LANES-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int N     = 1 << LOG2N;
    localparam int QTR   = N / 4;
    localparam int BEATS = N / (2 * LANES);
    localparam int AW    = LOG2N - 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0] STG_LIM = 4'(LOG2N);

    state_e r_state, w_next;
    logic   w_accept, w_reject;

    logic [3:0]       r_stage;
    logic             r_inv;
    logic [BW-1:0]    r_beat;
    logic             r_done;
    logic             r_p1_valid, r_p1_last;
    logic [LANES-1:0] r_p1_reneg;

    logic                  w_en, w_issue, w_beat_last;
    logic [3:0]            w_shamt;
    logic [LANES-1:0]      w_reneg;
    logic [2*DW*LANES-1:0] w_data;

    assign w_en        = !out_valid_o || out_ready_i;
    assign w_issue     = (r_state != ST_IDLE) && !r_done;
    assign w_beat_last = (r_beat == BW'(BEATS - 1));
    assign w_shamt     = 4'(AW) - r_stage;
    assign busy_o      = (r_state != ST_IDLE);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (stage_i < STG_LIM) begin
                        w_accept = 1'b1;
                        w_next   = ST_FILL;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_FILL: w_next = ST_RUN;
            ST_RUN: begin
                if (out_valid_o && out_ready_i && out_last_o) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [AW-1:0] w_j, w_e, w_addr_re, w_addr_im;
        logic [AW-2:0] w_lo;
        logic          w_hi;
        logic [DW-2:0] w_mag_re, w_mag_im;
        logic [DW-1:0] w_re, w_im_fwd, w_im;

        // Shifting left and truncating to AW bits keeps j mod 2^s scaled by 2^(AW-s).
        assign w_j  = AW'(int'(r_beat) * LANES + l);
        assign w_e  = w_j << w_shamt;
        assign w_hi = w_e[AW-1];
        assign w_lo = w_e[AW-2:0];

        assign w_addr_re  = w_hi ? (AW'(QTR) - AW'(w_lo)) : w_e;
        assign w_addr_im  = w_hi ? AW'(w_lo) : (AW'(QTR) - w_e);
        assign w_reneg[l] = w_hi;

        twiddle_qrom #(
            .LOG2N(LOG2N),
            .DW   (DW)
        ) u_qrom (
            .i_clk   (clock),
            .i_en    (w_en),
            .i_addr_a(w_addr_re),
            .i_addr_b(w_addr_im),
            .o_mag_a (w_mag_re),
            .o_mag_b (w_mag_im)
        );

        assign w_re     = DW'(sm_pack(r_p1_reneg[l], SM_MAXW'(w_mag_re), DW));
        assign w_im_fwd = DW'(sm_pack(1'b1, SM_MAXW'(w_mag_im), DW));
        assign w_im     = r_inv ? DW'(sm_negate(SM_MAXW'(w_im_fwd), DW)) : w_im_fwd;
        assign w_data[2*DW*(l+1)-1 -: 2*DW] = {w_re, w_im};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_stage     <= '0;
            r_inv       <= 1'b0;
            r_beat      <= '0;
            r_done      <= 1'b0;
            r_p1_valid  <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p1_reneg  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            r_state <= w_next;
            err_o   <= w_reject;
            if (w_accept) begin
                r_stage <= stage_i;
                r_inv   <= inverse_i;
                r_beat  <= '0;
                r_done  <= 1'b0;
            end else if (w_en && w_issue) begin
                if (w_beat_last) r_done <= 1'b1;
                else             r_beat <= r_beat + BW'(1);
            end
            if (w_en) begin
                r_p1_valid  <= w_issue;
                r_p1_last   <= w_issue && w_beat_last;
                r_p1_reneg  <= w_reneg;
                out_valid_o <= r_p1_valid;
                out_last_o  <= r_p1_last;
                out_data_o  <= r_p1_valid ? w_data : '0;
            end
        end
    end

endmodule
